// File: rtl/led_pattern_engine_if.sv
// led_pattern_engine_if
//   Board-side bundle for the LED pattern engine: switch/button inputs and
//   the LED/mode outputs. Clock and reset are kept as plain module ports.
//   master : drives i_sw/i_btn, observes the outputs (board top / bench)
//   slave  : the pattern engine itself
//   i_sw    [NB_SW]   [0] enable, [2:1] rate, [3] rotate direction
//   i_btn   [NB_SW]   [0] mode, [1] red, [2] green, [3] blue (asynchronous)
//   o_led   [N_LEDS]  current pattern
//   o_led_r/g/b       pattern gated by the selected colour
//   o_mode  [2]       0 ROTATE, 1 FLASH, 2 BOUNCE
interface led_pattern_engine_if #(
  parameter int N_LEDS = 4,
  parameter int NB_SW  = 4
);
  logic [NB_SW-1:0]  i_sw;
  logic [NB_SW-1:0]  i_btn;
  logic [N_LEDS-1:0] o_led;
  logic [N_LEDS-1:0] o_led_r;
  logic [N_LEDS-1:0] o_led_g;
  logic [N_LEDS-1:0] o_led_b;
  logic [1:0]        o_mode;

  modport master (
    output i_sw, i_btn,
    input  o_led, o_led_r, o_led_g, o_led_b, o_mode
  );

  modport slave (
    input  i_sw, i_btn,
    output o_led, o_led_r, o_led_g, o_led_b, o_mode
  );
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//   N-wide LED pattern generator with rotate / flash / bounce modes, four
//   selectable tick rates and a colour select that steers the pattern onto
//   one of three RGB banks.
//   clock   : system clock
//   i_reset : asynchronous, active-low reset
//   bus     : slave side of led_pattern_engine_if (switches, buttons, LEDs,
//             mode)
module led_pattern_engine #(
  parameter int N_LEDS   = 4,
  parameter int NB_COUNT = 11,
  parameter int NB_SW    = 4,
  parameter int R0_LIMIT = 255,
  parameter int R1_LIMIT = 511,
  parameter int R2_LIMIT = 1023,
  parameter int R3_LIMIT = 2047
) (
  input  logic                  clock,
  input  logic                  i_reset,
  led_pattern_engine_if.slave   bus
);

  localparam logic [1:0] MODE_ROTATE = 2'd0;
  localparam logic [1:0] MODE_FLASH  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam logic [1:0] COL_RED   = 2'd0;
  localparam logic [1:0] COL_GREEN = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [N_LEDS-1:0] PAT_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Button synchroniser + rising-edge detector, one chain per button.
  // ---------------------------------------------------------------------
  logic [NB_SW-1:0] btn_meta_reg;
  logic [NB_SW-1:0] btn_sync_reg;
  logic [NB_SW-1:0] btn_last_reg;
  logic [NB_SW-1:0] btn_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < NB_SW; gi++) begin : g_btn
      always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
          btn_meta_reg[gi] <= 1'b0;
          btn_sync_reg[gi] <= 1'b0;
          btn_last_reg[gi] <= 1'b0;
        end else begin
          btn_meta_reg[gi] <= bus.i_btn[gi];
          btn_sync_reg[gi] <= btn_meta_reg[gi];
          btn_last_reg[gi] <= btn_sync_reg[gi];
        end
      end
      assign btn_pulse[gi] = btn_sync_reg[gi] & ~btn_last_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [NB_COUNT-1:0] count_reg,   count_next;
  logic [N_LEDS-1:0]   pattern_reg, pattern_next;
  logic [1:0]          mode_reg,    mode_next;
  logic [1:0]          colour_reg,  colour_next;
  logic                dir_reg,     dir_next;

  logic [NB_COUNT-1:0] limit;
  logic                tick;

  always_comb begin
    case (bus.i_sw[2:1])
      2'd0:    limit = NB_COUNT'(R0_LIMIT);
      2'd1:    limit = NB_COUNT'(R1_LIMIT);
      2'd2:    limit = NB_COUNT'(R2_LIMIT);
      default: limit = NB_COUNT'(R3_LIMIT);
    endcase
  end

  // >= rather than == so that dropping to a faster rate mid-count ticks
  // immediately instead of running on to the counter wrap.
  assign tick = (count_reg >= limit) && bus.i_sw[0];

  always_comb begin
    count_next   = count_reg;
    pattern_next = pattern_reg;
    mode_next    = mode_reg;
    dir_next     = dir_reg;
    colour_next  = colour_reg;

    if (btn_pulse[0]) begin
      // A mode change discards any tick coinciding with it.
      count_next = '0;
      dir_next   = DIR_UP;
      case (mode_reg)
        MODE_ROTATE: begin
          mode_next    = MODE_FLASH;
          pattern_next = '1;
        end
        MODE_FLASH: begin
          mode_next    = MODE_BOUNCE;
          pattern_next = PAT_ONE;
        end
        default: begin
          mode_next    = MODE_ROTATE;
          pattern_next = PAT_ONE;
        end
      endcase
    end else if (bus.i_sw[0]) begin
      if (tick) begin
        count_next = '0;
        case (mode_reg)
          MODE_ROTATE: begin
            if (bus.i_sw[3])
              pattern_next = {pattern_reg[0], pattern_reg[N_LEDS-1:1]};
            else
              pattern_next = {pattern_reg[N_LEDS-2:0], pattern_reg[N_LEDS-1]};
          end
          MODE_FLASH: begin
            pattern_next = ~pattern_reg;
          end
          default: begin
            // Bounce reverses on reaching either end, so each end LED is
            // lit for a single tick.
            if (dir_reg == DIR_UP) begin
              if (pattern_reg[N_LEDS-1]) begin
                dir_next     = DIR_DOWN;
                pattern_next = pattern_reg >> 1;
              end else begin
                pattern_next = pattern_reg << 1;
              end
            end else begin
              if (pattern_reg[0]) begin
                dir_next     = DIR_UP;
                pattern_next = pattern_reg << 1;
              end else begin
                pattern_next = pattern_reg >> 1;
              end
            end
          end
        endcase
      end else begin
        count_next = count_reg + NB_COUNT'(1);
      end
    end

    if (btn_pulse[3])
      colour_next = COL_BLUE;
    else if (btn_pulse[2])
      colour_next = COL_GREEN;
    else if (btn_pulse[1])
      colour_next = COL_RED;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_reg   <= '0;
      pattern_reg <= PAT_ONE;
      mode_reg    <= MODE_ROTATE;
      colour_reg  <= COL_RED;
      dir_reg     <= DIR_UP;
    end else begin
      count_reg   <= count_next;
      pattern_reg <= pattern_next;
      mode_reg    <= mode_next;
      colour_reg  <= colour_next;
      dir_reg     <= dir_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.o_led  = pattern_reg;
  assign bus.o_mode = mode_reg;

  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_rgb
      assign bus.o_led_r[gi] = pattern_reg[gi] & (colour_reg == COL_RED);
      assign bus.o_led_g[gi] = pattern_reg[gi] & (colour_reg == COL_GREEN);
      assign bus.o_led_b[gi] = pattern_reg[gi] & (colour_reg == COL_BLUE);
    end
  endgenerate

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  localparam int N = 4;
  localparam int LIM0 = 3;
  localparam int LIM1 = 5;
  localparam int LIM2 = 7;
  localparam int LIM3 = 15;

  logic clock = 1'b0;
  logic i_reset = 1'b0;

  led_pattern_engine_if #(.N_LEDS(N), .NB_SW(4)) bus ();

  led_pattern_engine #(
    .N_LEDS(N), .NB_COUNT(11), .NB_SW(4),
    .R0_LIMIT(LIM0), .R1_LIMIT(LIM1), .R2_LIMIT(LIM2), .R3_LIMIT(LIM3)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit check_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Behavioural model. The lit LED is tracked as a position index and
  // FLASH as an on/off flag; buttons as a history of sampled levels.
  // -------------------------------------------------------------------
  int   m_mode, m_pos, m_colour, m_count;
  bit   m_flash_on, m_dir_up;
  logic [3:0] h1, h2, h3;   // button levels sampled 1, 2, 3 edges ago
  int   lim_tab [4] = '{LIM0, LIM1, LIM2, LIM3};

  always @(posedge clock or negedge i_reset) begin : model
    automatic logic [3:0] pulse;
    automatic int n_mode, n_pos, n_colour, n_count;
    automatic bit n_flash, n_up, en;
    if (!i_reset) begin
      m_mode <= 0; m_pos <= 0; m_colour <= 0; m_count <= 0;
      m_flash_on <= 1'b1; m_dir_up <= 1'b1;
      h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      // A level first sampled two edges ago, low three edges ago, acts now.
      pulse = h2 & ~h3;
      n_mode = m_mode; n_pos = m_pos; n_colour = m_colour; n_count = m_count;
      n_flash = m_flash_on; n_up = m_dir_up;
      en = bus.i_sw[0];
      if (pulse[0]) begin
        n_mode = (m_mode + 1) % 3;
        n_count = 0; n_pos = 0; n_flash = 1'b1; n_up = 1'b1;
      end else if (en) begin
        if (m_count >= lim_tab[bus.i_sw[2:1]]) begin
          n_count = 0;
          if (m_mode == 0) begin
            n_pos = bus.i_sw[3] ? (m_pos + N - 1) % N : (m_pos + 1) % N;
          end else if (m_mode == 1) begin
            n_flash = !m_flash_on;
          end else begin
            if (m_dir_up) begin
              if (m_pos == N - 1) begin n_up = 1'b0; n_pos = N - 2; end
              else n_pos = m_pos + 1;
            end else begin
              if (m_pos == 0) begin n_up = 1'b1; n_pos = 1; end
              else n_pos = m_pos - 1;
            end
          end
        end else begin
          n_count = m_count + 1;
        end
      end
      if (pulse[3]) n_colour = 2;
      else if (pulse[2]) n_colour = 1;
      else if (pulse[1]) n_colour = 0;
      m_mode <= n_mode; m_pos <= n_pos; m_colour <= n_colour; m_count <= n_count;
      m_flash_on <= n_flash; m_dir_up <= n_up;
      h1 <= bus.i_btn; h2 <= h1; h3 <= h2;
    end
  end

  function automatic logic [N-1:0] m_led();
    if (m_mode == 1) return m_flash_on ? {N{1'b1}} : {N{1'b0}};
    return N'(1) << m_pos;
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (check_on) begin
      chk("o_led",   32'(bus.o_led),   32'(m_led()));
      chk("o_led_r", 32'(bus.o_led_r), 32'(m_colour == 0 ? m_led() : '0));
      chk("o_led_g", 32'(bus.o_led_g), 32'(m_colour == 1 ? m_led() : '0));
      chk("o_led_b", 32'(bus.o_led_b), 32'(m_colour == 2 ? m_led() : '0));
      chk("o_mode",  32'(bus.o_mode),  32'(m_mode));
    end
  end

  task automatic press(input logic [3:0] b, input int hold);
    bus.i_btn = b;
    repeat (hold) @(negedge clock);
    bus.i_btn = 4'b0000;
    repeat (3) @(negedge clock);
  endtask

  logic [N-1:0] seq_got [$];
  logic [N-1:0] seq_exp [6];
  logic [N-1:0] prev_led;
  bit found;

  initial begin
    bus.i_sw  = 4'b0000;
    bus.i_btn = 4'b0000;
    i_reset   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_led",  32'(bus.o_led),   32'h1);
    chk("rst_r",    32'(bus.o_led_r), 32'h1);
    chk("rst_g",    32'(bus.o_led_g), 32'h0);
    chk("rst_b",    32'(bus.o_led_b), 32'h0);
    chk("rst_mode", 32'(bus.o_mode),  32'h0);

    // Rotate left at rate 0: one step every 4 enabled clocks.
    bus.i_sw = 4'b0001;
    i_reset  = 1'b1;
    check_on = 1'b1;
    repeat (3) @(negedge clock);
    chk("rot_hold", 32'(bus.o_led), 32'b0001);
    @(negedge clock);
    chk("rot_step1", 32'(bus.o_led), 32'b0010);
    repeat (4) @(negedge clock);
    chk("rot_step2", 32'(bus.o_led), 32'b0100);
    bus.i_sw = 4'b1001;
    repeat (4) @(negedge clock);
    chk("rot_right1", 32'(bus.o_led), 32'b0010);
    repeat (4) @(negedge clock);
    chk("rot_right2", 32'(bus.o_led), 32'b0001);
    repeat (4) @(negedge clock);
    chk("rot_right_wrap", 32'(bus.o_led), 32'b1000);

    // Mode press held 5 cycles: mode advances once, at the third edge.
    bus.i_sw  = 4'b0001;
    bus.i_btn = 4'b0001;
    @(negedge clock);
    @(negedge clock);
    chk("mode_lat_k1", 32'(bus.o_mode), 32'd0);
    @(negedge clock);
    chk("mode_flash", 32'(bus.o_mode), 32'd1);
    chk("flash_entry", 32'(bus.o_led), 32'hF);
    repeat (2) @(negedge clock);
    bus.i_btn = 4'b0000;
    repeat (4) @(negedge clock);
    chk("mode_once", 32'(bus.o_mode), 32'd1);
    repeat (8) @(negedge clock);

    // Second press: BOUNCE, then record the bounce sequence.
    bus.i_btn = 4'b0001;
    repeat (3) @(negedge clock);
    bus.i_btn = 4'b0000;
    chk("mode_bounce", 32'(bus.o_mode), 32'd2);
    chk("bounce_entry", 32'(bus.o_led), 32'b0001);
    seq_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    prev_led = bus.o_led;
    seq_got.delete();
    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      if (bus.o_led != prev_led) seq_got.push_back(bus.o_led);
      prev_led = bus.o_led;
    end
    chk("bounce_len", 32'(seq_got.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bounce_seq%0d", i),
          32'(i < seq_got.size() ? seq_got[i] : 'x), 32'(seq_exp[i]));

    // Colours.
    press(4'b0100, 2);
    chk("green_r", 32'(bus.o_led_r), 32'h0);
    chk("green_g", 32'(bus.o_led_g), 32'(m_led()));
    press(4'b1000, 2);
    press(4'b1000, 2);
    chk("blue_twice", 32'(bus.o_led_b), 32'(m_led()));
    press(4'b0100, 1);
    press(4'b1100, 1);
    chk("blue_prio", 32'(bus.o_led_b), 32'(m_led()));
    chk("blue_prio_g", 32'(bus.o_led_g), 32'h0);
    press(4'b0110, 1);
    chk("green_prio", 32'(bus.o_led_g), 32'(m_led()));

    // Freeze with enable cleared (model comparison covers the hold).
    bus.i_sw = 4'b0000;
    repeat (20) @(negedge clock);
    bus.i_sw = 4'b0001;
    repeat (10) @(negedge clock);

    // Back to ROTATE, then a mid-count drop from rate 3 to rate 0.
    press(4'b0001, 1);
    chk("mode_rotate", 32'(bus.o_mode), 32'd0);
    bus.i_sw = 4'b0111;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (m_count == 10) found = 1'b1;
    end
    chk("rate_wait", 32'(found), 32'd1);
    chk("rate_before", 32'(bus.o_led), 32'b0001);
    bus.i_sw = 4'b0001;
    @(negedge clock);
    chk("rate_drop_tick", 32'(bus.o_led), 32'b0010);

    // Asynchronous reset mid-FLASH.
    press(4'b0001, 1);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_led",  32'(bus.o_led),   32'b0001);
    chk("arst_mode", 32'(bus.o_mode),  32'd0);
    chk("arst_r",    32'(bus.o_led_r), 32'b0001);
    @(negedge clock);
    i_reset = 1'b1;

    // Randomised phase.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) begin
        bus.i_sw = 4'($urandom);
        bus.i_sw[0] = ($urandom_range(0, 3) != 0);
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) bus.i_btn[b] = ~bus.i_btn[b];
      if ($urandom_range(0, 499) == 0) begin
        #2 i_reset = 1'b0;
        @(negedge clock);
        i_reset = 1'b1;
      end
    end

    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator driving an N-wide bank of plain LEDs and a matching RGB bank from board switches and push-buttons. It generalises the fixed four-LED shift/flash design in four ways: any LED count, three pattern modes (rotate, flash, bounce), per-instance rate limits, and synchronised, edge-detected buttons with defined priority. It sits directly under the board top, between the synchronised board I/O and the LED pins.

## Interface
- N_LEDS, 4, LED count; must be ≥ 2.
- NB_COUNT, 11, tick counter width.
- NB_SW, 4, switch and button bus width; fixed at 4.
- R0_LIMIT, 255, counter terminal value for rate 0. The tick period is R0_LIMIT+1 enabled cycles.
- R1_LIMIT, 511, terminal value for rate 1.
- R2_LIMIT, 1023, terminal value for rate 2.
- R3_LIMIT, 2047, terminal value for rate 3. Every limit must be < 2^NB_COUNT.
- clock  in  1  system clock; the only clock in the block.
- i_reset  in  1  reset; asynchronous, active-low.
- i_sw  in  NB_SW  [0] counter enable, [2:1] rate select, [3] rotate direction (0 = toward MSB, 1 = toward LSB). Quasi-static; not synchronised.
- i_btn  in  NB_SW  [0] mode advance, [1] red, [2] green, [3] blue. Asynchronous; synchronised internally.
- o_led  out  N_LEDS  current pattern, registered.
- o_led_r  out  N_LEDS  o_led gated by colour == red.
- o_led_g  out  N_LEDS  o_led gated by colour == green.
- o_led_b  out  N_LEDS  o_led gated by colour == blue.
- o_mode  out  2  0 = ROTATE, 1 = FLASH, 2 = BOUNCE; registered.

## Operation
- **Reset** (i_reset = 0, async):
  - count = 0, pattern = 1 (LSB only), mode = ROTATE, colour = red, bounce direction = up, sync/edge flops = 0.
  - Resulting outputs: o_led = 1, o_led_r = 1, o_led_g = o_led_b = 0, o_mode = 0.
- **Buttons:**
  - Each i_btn bit passes through a 2-flop synchroniser and a rising-edge detector, giving a one-cycle press pulse.
  - A held button produces exactly one pulse.
- **Mode register:**
  - A btn0 pulse advances ROTATE → FLASH → BOUNCE → ROTATE.
  - On any mode change: count cleared.
  - Pattern on entry: all-ones when entering FLASH; 1 when entering ROTATE or BOUNCE. Bounce direction = up.
- **Colour register:**
  - Priority when several colour pulses occur in one cycle: blue > green > red.
  - Re-pressing the current colour changes nothing.
  - Colour changes never alter pattern, count or mode.
- **Tick counter:**
  - Advances only when i_sw[0] = 1.
  - tick = (count ≥ limit[i_sw[2:1]]) && i_sw[0]. On tick, count ← 0; otherwise count ← count + 1.
  - The ≥ compare means a rate change to a smaller limit mid-count ticks on the next enabled cycle. No wrap-around past the limit is possible.
  - With i_sw[0] = 0, count and pattern hold.
- **Pattern on tick:**
  - ROTATE: rotate left by 1 if i_sw[3] = 0, right by 1 if 1. The MSB/LSB wrap, so exactly one bit is always lit.
  - FLASH: pattern ← ~pattern (all-ones ↔ all-zeros).
  - BOUNCE with direction up: if pattern[N_LEDS-1], set direction = down and shift right; else shift left.
  - BOUNCE with direction down: if pattern[0], set direction = up and shift left; else shift right.
  - Bounce period is 2·N_LEDS−2 ticks. i_sw[3] is ignored in BOUNCE.
- **Collisions:**
  - A mode pulse and a tick in the same cycle: the mode change wins and the tick is discarded.
  - Reset asserted mid-operation: all state returns to its reset values immediately.

## Timing
- Button latency: the rising i_btn is first sampled at edge k. The pulse is active during cycle k+1→k+2. mode/colour and o_mode/o_led_* update at edge k+2.
- Tick latency: the pattern updates at the same edge where count returns to 0. o_led changes exactly one edge after the tick condition is true.
- Colour outputs are combinational from the registered pattern and registered colour. They carry no additional latency.
- i_sw changes take effect in the cycle in which they are sampled, with no synchronisation latency.

## Test plan
- Parameters N_LEDS = 4, R0_LIMIT = 3, switches i_sw = 4'b0001, reset released → o_led steps 0001, 0010, 0100, 1000, 0001, one step every 4 clocks. o_led_r tracks o_led; o_led_g = o_led_b = 0.
- Set i_sw[3] = 1 while o_led = 0100 → following ticks give 0010, 0001, 1000.
- Press btn0 once and hold it 5 cycles → o_mode = 1 exactly once, o_led = 1111 two edges after the press is sampled, then alternating 0000/1111 every 4 clocks. A second press → o_mode = 2, o_led = 0001, then 0010, 0100, 1000, 0100, 0010, 0001.
- Press btn2 → o_led_g = o_led, o_led_r = 0. Press btn3 twice → blue stays blue. Press btn2 and btn3 in the same cycle → blue.
- Clear i_sw[0] for 20 cycles → o_led frozen. Set it again → the next step comes after the remaining count.
- Rate checks: with R3_LIMIT = 15 at count = 10, switch to rate 0 (limit 3) → tick on the next enabled cycle. Assert i_reset = 0 mid-FLASH → o_led = 0001, o_mode = 0, o_led_r = 0001 asynchronously.
